// File: rtl/leiwand_rv32_bus_arbiter.sv
// Two-master round-robin arbiter in front of a single RAM slave.
// Ownership is held for a whole bus cycle; a watchdog aborts stuck slaves.
module leiwand_rv32_bus_arbiter #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_m0_cyc,
   input  logic                  i_m0_stb,
   input  logic                  i_m0_we,
   input  logic [ADDR_WIDTH-1:0] i_m0_addr,
   input  logic [DATA_WIDTH-1:0] i_m0_dat,
   output logic [DATA_WIDTH-1:0] o_m0_dat,
   output logic                  o_m0_ack,
   output logic                  o_m0_stall,
   output logic                  o_m0_err,
   input  logic                  i_m1_cyc,
   input  logic                  i_m1_stb,
   input  logic                  i_m1_we,
   input  logic [ADDR_WIDTH-1:0] i_m1_addr,
   input  logic [DATA_WIDTH-1:0] i_m1_dat,
   output logic [DATA_WIDTH-1:0] o_m1_dat,
   output logic                  o_m1_ack,
   output logic                  o_m1_stall,
   output logic                  o_m1_err,
   output logic                  o_s_cyc,
   output logic                  o_s_stb,
   output logic                  o_s_we,
   output logic [ADDR_WIDTH-1:0] o_s_addr,
   output logic [DATA_WIDTH-1:0] o_s_dat,
   input  logic [DATA_WIDTH-1:0] i_s_dat,
   input  logic                  i_s_ack,
   input  logic                  i_s_stall
);

   localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t           state;
   logic             owner;
   logic             last_grant;
   logic [CNT_W-1:0] wd_cnt;

   logic                  own_cyc;
   logic                  own_stb;
   logic                  own_we;
   logic [ADDR_WIDTH-1:0] own_addr;
   logic [DATA_WIDTH-1:0] own_dat;
   logic                  busy;
   logic                  wd_expire;

   // Select the current owner's request lines
   always_comb begin
      own_cyc  = owner ? i_m1_cyc  : i_m0_cyc;
      own_stb  = owner ? i_m1_stb  : i_m0_stb;
      own_we   = owner ? i_m1_we   : i_m0_we;
      own_addr = owner ? i_m1_addr : i_m0_addr;
      own_dat  = owner ? i_m1_dat  : i_m0_dat;
   end

   assign busy = (state == BUSY);

   // Owner release wins over expiry because own_cyc gates the expiry term
   assign wd_expire = busy && own_cyc && (TIMEOUT != 0) &&
                      (wd_cnt == CNT_W'(TIMEOUT)) && !i_s_ack;

   always_comb begin
      o_s_cyc    = 1'b0;
      o_s_stb    = 1'b0;
      o_s_we     = 1'b0;
      o_s_addr   = '0;
      o_s_dat    = '0;
      o_m0_dat   = '0;
      o_m0_ack   = 1'b0;
      o_m0_stall = 1'b1;
      o_m0_err   = 1'b0;
      o_m1_dat   = '0;
      o_m1_ack   = 1'b0;
      o_m1_stall = 1'b1;
      o_m1_err   = 1'b0;
      if (busy) begin
         o_s_cyc  = own_cyc;
         o_s_stb  = own_stb;
         o_s_we   = own_we;
         o_s_addr = own_addr;
         o_s_dat  = own_dat;
         if (owner) begin
            o_m1_dat   = i_s_dat;
            o_m1_ack   = i_s_ack;
            o_m1_stall = i_s_stall;
            o_m1_err   = wd_expire;
         end else begin
            o_m0_dat   = i_s_dat;
            o_m0_ack   = i_s_ack;
            o_m0_stall = i_s_stall;
            o_m0_err   = wd_expire;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         wd_cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_m0_cyc || i_m1_cyc) begin
                  state  <= BUSY;
                  owner  <= (i_m0_cyc && i_m1_cyc) ? !last_grant : i_m1_cyc;
                  wd_cnt <= '0;
               end
            end
            BUSY: begin
               if (!own_cyc) begin
                  state      <= IDLE;
                  last_grant <= owner;
               end else if (wd_expire) begin
                  state <= DRAIN;
               end else if (i_s_ack) begin
                  wd_cnt <= '0;
               end else begin
                  wd_cnt <= wd_cnt + CNT_W'(1);
               end
            end
            DRAIN: begin
               if (!own_cyc) begin
                  state      <= IDLE;
                  last_grant <= owner;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_leiwand_rv32_bus_arbiter.sv
// Scoreboard bench for the bus arbiter: directed master traffic, a simple
// acking RAM model, and a monitor that checks slave transfers and grant order.
module tb_leiwand_rv32_bus_arbiter;

   logic        i_clk, i_rst;
   logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
   logic [31:0] m0_addr, m1_addr;
   logic [7:0]  m0_wdat, m1_wdat;
   logic [7:0]  o_m0_dat, o_m1_dat;
   logic        o_m0_ack, o_m0_stall, o_m0_err, o_m1_ack, o_m1_stall, o_m1_err;
   logic        o_s_cyc, o_s_stb, o_s_we;
   logic [31:0] o_s_addr;
   logic [7:0]  o_s_dat;
   logic [7:0]  i_s_dat;
   logic        i_s_ack, i_s_stall;

   leiwand_rv32_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(8), .TIMEOUT(4)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we),
      .i_m0_addr(m0_addr), .i_m0_dat(m0_wdat),
      .o_m0_dat(o_m0_dat), .o_m0_ack(o_m0_ack), .o_m0_stall(o_m0_stall), .o_m0_err(o_m0_err),
      .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we),
      .i_m1_addr(m1_addr), .i_m1_dat(m1_wdat),
      .o_m1_dat(o_m1_dat), .o_m1_ack(o_m1_ack), .o_m1_stall(o_m1_stall), .o_m1_err(o_m1_err),
      .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we),
      .o_s_addr(o_s_addr), .o_s_dat(o_s_dat),
      .i_s_dat(i_s_dat), .i_s_ack(i_s_ack), .i_s_stall(i_s_stall)
   );

   typedef struct {
      int          m;
      logic        we;
      logic [31:0] addr;
      logic [7:0]  wd;
      logic [7:0]  rd;
   } txn_t;

   txn_t exp_q[$];
   int   exp_g[$];
   int   passed = 0;
   int   total  = 0;
   bit   s_mute = 0;
   int   s_delay = 2;
   int   s_cnt = 0;
   bit   m1_rel = 0;
   logic prev_cyc = 0;

   initial begin
      i_clk = 0;
      forever #5 i_clk = ~i_clk;
   end

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endfunction

   function automatic void push_txn(input int m, input logic we, input logic [31:0] a,
                                    input logic [7:0] wd, input logic [7:0] rd);
      txn_t t;
      t.m = m; t.we = we; t.addr = a; t.wd = wd; t.rd = rd;
      exp_q.push_back(t);
   endfunction

   function automatic logic ack_of(input int m);
      return (m == 0) ? o_m0_ack : o_m1_ack;
   endfunction

   task automatic drive(input int m, input logic c, input logic s, input logic w,
                        input logic [31:0] a, input logic [7:0] d);
      if (m == 0) begin
         m0_cyc = c; m0_stb = s; m0_we = w; m0_addr = a; m0_wdat = d;
      end else begin
         m1_cyc = c; m1_stb = s; m1_we = w; m1_addr = a; m1_wdat = d;
      end
   endtask

   task automatic m_req(input int m, input logic we, input logic [31:0] a, input logic [7:0] d);
      drive(m, 1'b1, 1'b1, we, a, d);
   endtask

   // Wait for the ack, then drop stb (and cyc unless the master keeps the bus)
   task automatic m_wait_ack(input int m, input bit keep);
      bit got = 0;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge i_clk); #2;
         if (ack_of(m)) got = 1;
      end
      if (!got) begin
         total++;
         $display("FAIL ack_wait_m%0d: no ack within 60 cycles", m);
      end
      @(posedge i_clk); #1;
      drive(m, keep, 1'b0, 1'b0, 32'h0, 8'h0);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge i_clk); #1; end
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_s_cyc"}, o_s_cyc, 0);
      chk({tag, "_s_stb"}, o_s_stb, 0);
      chk({tag, "_m0_stall"}, o_m0_stall, 1);
      chk({tag, "_m1_stall"}, o_m1_stall, 1);
      chk({tag, "_acks"}, {o_m0_ack, o_m1_ack}, 0);
      chk({tag, "_errs"}, {o_m0_err, o_m1_err}, 0);
      chk({tag, "_dats"}, {o_m0_dat, o_m1_dat}, 0);
   endtask

   // RAM model: ack after s_delay cycles of stb, read data = addr[7:0] ^ 0xA1
   initial begin
      i_s_ack = 0; i_s_dat = 0; i_s_stall = 0;
      forever begin
         @(negedge i_clk);
         if (i_s_ack) begin
            i_s_ack = 0;
            s_cnt = 0;
         end else if (o_s_cyc && o_s_stb && !s_mute) begin
            s_cnt++;
            if (s_cnt >= s_delay) begin
               i_s_ack = 1;
               i_s_dat = o_s_addr[7:0] ^ 8'hA1;
            end
         end else begin
            s_cnt = 0;
         end
      end
   end

   // Monitor: grant order on each o_s_cyc rise, transfer contents on each ack
   initial begin
      forever begin
         @(negedge i_clk); #2;
         if (o_s_cyc && !prev_cyc) begin
            if (exp_g.size() == 0) begin
               total++;
               $display("FAIL grant_unexpected: m%0d granted with nothing expected", o_m1_stall ? 0 : 1);
            end else begin
               chk("grant_order", {31'b0, !o_m1_stall}, exp_g.pop_front());
            end
         end
         prev_cyc = o_s_cyc;
         if (o_s_cyc && o_s_stb && i_s_ack) begin
            if (exp_q.size() == 0) begin
               total++;
               $display("FAIL txn_unexpected: ack at addr %0h", o_s_addr);
            end else begin
               txn_t t;
               t = exp_q.pop_front();
               chk("txn_owner_ack", ack_of(t.m), 1);
               chk("txn_other_ack", ack_of(1 - t.m), 0);
               chk("txn_other_stall", (t.m == 0) ? o_m1_stall : o_m0_stall, 1);
               chk("txn_other_dat", (t.m == 0) ? o_m1_dat : o_m0_dat, 0);
               chk("txn_we", o_s_we, t.we);
               chk("txn_addr", o_s_addr, t.addr);
               if (t.we) chk("txn_wdat", o_s_dat, t.wd);
               else      chk("txn_rdat", (t.m == 0) ? o_m0_dat : o_m1_dat, t.rd);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      logic [7:0] d0 [3];
      logic [7:0] d1 [3];
      d0 = '{8'h11, 8'h33, 8'h55};
      d1 = '{8'h22, 8'h44, 8'h66};
      i_rst = 1;
      drive(0, 0, 0, 0, 32'h0, 8'h0);
      drive(1, 0, 0, 0, 32'h0, 8'h0);
      repeat (3) @(negedge i_clk);
      #2;
      chk_reset_outs("reset");
      @(negedge i_clk);
      i_rst = 0;
      idle(1);

      // Contention rounds: m0 first after reset, strict alternation afterwards
      for (int r = 0; r < 3; r++) begin
         push_txn(0, 1, 32'(2 * r), d0[r], 8'h0);
         push_txn(1, 1, 32'(2 * r + 1), d1[r], 8'h0);
         exp_g.push_back(0);
         exp_g.push_back(1);
         fork
            begin m_req(0, 1, 32'(2 * r), d0[r]); m_wait_ack(0, 0); end
            begin m_req(1, 1, 32'(2 * r + 1), d1[r]); m_wait_ack(1, 0); end
         join
         idle(1);
      end
      idle(1);

      // Single read, one-cycle grant latency
      push_txn(0, 0, 32'h4, 8'h0, 8'hA5);
      exp_g.push_back(0);
      m_req(0, 0, 32'h4, 8'h0);
      @(negedge i_clk); #2;
      chk("read_lat_idle_cyc", o_s_cyc, 0);
      @(negedge i_clk); #2;
      chk("read_lat_busy_cyc", o_s_cyc, 1);
      chk("read_addr", o_s_addr, 32'h4);
      chk("read_m1_stall", o_m1_stall, 1);
      m_wait_ack(0, 0);
      idle(2);

      // Hold: m1 keeps cyc over two transfers while m0 waits
      push_txn(1, 1, 32'h20, 8'h5A, 8'h0);
      push_txn(1, 1, 32'h21, 8'h5B, 8'h0);
      push_txn(0, 1, 32'h22, 8'h5C, 8'h0);
      exp_g.push_back(1);
      exp_g.push_back(0);
      m1_rel = 0;
      fork
         begin
            m_req(1, 1, 32'h20, 8'h5A); m_wait_ack(1, 1);
            m_req(1, 1, 32'h21, 8'h5B); m_wait_ack(1, 0);
            m1_rel = 1;
         end
         begin idle(1); m_req(0, 1, 32'h22, 8'h5C); m_wait_ack(0, 0); end
         begin
            bit rel = 0;
            for (int i = 0; i < 60 && !rel; i++) begin
               @(negedge i_clk); #2;
               if (m1_rel) rel = 1;
               else chk("hold_m0_stall", o_m0_stall, 1);
            end
            chk("hold_rel_m0_stall", o_m0_stall, 1);
            chk("hold_rel_s_cyc", o_s_cyc, 0);
            @(negedge i_clk); #2;
            chk("hold_gap_m0_stall", o_m0_stall, 1);
            chk("hold_gap_s_cyc", o_s_cyc, 0);
            @(negedge i_clk); #2;
            chk("hold_grant_m0_stall", o_m0_stall, 0);
            chk("hold_grant_s_cyc", o_s_cyc, 1);
         end
      join
      idle(2);

      // Watchdog (TIMEOUT=4): BUSY cycles numbered from 0, err in BUSY cycle 4
      s_mute = 1;
      exp_g.push_back(0);
      exp_g.push_back(1);
      push_txn(1, 1, 32'h9, 8'h77, 8'h0);
      m_req(0, 0, 32'h8, 8'h0);
      for (int k = 0; k < 8; k++) begin
         @(negedge i_clk); #2;
         chk($sformatf("wd_err_k%0d", k), o_m0_err, (k == 5) ? 1 : 0);
         chk($sformatf("wd_s_cyc_k%0d", k), o_s_cyc, (k >= 1 && k <= 5) ? 1 : 0);
      end
      idle(1);
      m_req(1, 1, 32'h9, 8'h77);
      @(negedge i_clk); #2;
      chk("drain_m1_stall", o_m1_stall, 1);
      chk("drain_s_cyc", o_s_cyc, 0);
      @(posedge i_clk); #1;
      drive(0, 0, 0, 0, 32'h0, 8'h0);
      s_mute = 0;
      m_wait_ack(1, 0);
      idle(2);

      // Asynchronous reset in the middle of a BUSY transfer
      s_mute = 1;
      exp_g.push_back(0);
      m_req(0, 1, 32'h30, 8'h99);
      @(negedge i_clk); #2;
      @(negedge i_clk); #2;
      chk("rst_mid_pre_s_cyc", o_s_cyc, 1);
      #1 i_rst = 1;
      #1 chk_reset_outs("rst_mid");
      drive(0, 0, 0, 0, 32'h0, 8'h0);
      @(negedge i_clk);
      i_rst = 0;
      s_mute = 0;
      idle(1);

      // After reset m0 wins simultaneous requests again
      push_txn(0, 1, 32'h40, 8'hC0, 8'h0);
      push_txn(1, 0, 32'h41, 8'h0, 8'hE0);
      exp_g.push_back(0);
      exp_g.push_back(1);
      fork
         begin m_req(0, 1, 32'h40, 8'hC0); m_wait_ack(0, 0); end
         begin m_req(1, 0, 32'h41, 8'h0); m_wait_ack(1, 0); end
      join
      idle(3);

      chk("txn_queue_empty", exp_q.size(), 0);
      chk("grant_queue_empty", exp_g.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
